// File: rtl/score_render.sv
// score_render: keeps the game score as 4-digit BCD and renders it from an 8x16 digit glyph ROM.
// A per-frame snapshot of the score feeds a two-stage pixel pipeline, so the score never tears mid-frame.
module score_render #(
  parameter logic [9:0] X0       = 10'd560,
  parameter logic [9:0] Y0       = 10'd16,
  parameter bit         BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        frame_start,
  input  logic        score_tick,
  input  logic        score_clr,
  input  logic        freeze,
  output logic [7:0]  rom_addr,
  input  logic [7:0]  rom_data,
  output logic [15:0] score_bcd,
  output logic        sat,
  output logic        pixel_on
);

  logic [15:0] next_bcd;
  logic [15:0] disp_bcd;
  logic        in_reg;
  logic [4:0]  dx;
  logic [3:0]  dy;
  logic [3:0]  digit;
  logic        blank;
  logic        zero_th;
  logic        zero_hu;
  logic        zero_te;
  logic [2:0]  col_r;
  logic        lit_r;

  // Ripple-carry BCD increment: nibbles at 9 wrap to 0 and pass the carry upward.
  always_comb begin
    logic carry;
    next_bcd = score_bcd;
    carry    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (score_bcd[4*i +: 4] == 4'd9) begin
          next_bcd[4*i +: 4] = 4'd0;
        end else begin
          next_bcd[4*i +: 4] = score_bcd[4*i +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_bcd <= 16'h0000;
      sat       <= 1'b0;
    end else if (score_clr) begin
      score_bcd <= 16'h0000;
      sat       <= 1'b0;
    end else if (score_tick && !freeze) begin
      if (score_bcd == 16'h9999)
        sat <= 1'b1;
      else
        score_bcd <= next_bcd;
    end
  end

  // The snapshot samples the pre-update score when a tick lands on frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      disp_bcd <= 16'h0000;
    else if (frame_start)
      disp_bcd <= score_bcd;
  end

  // Only the low bits of the offsets matter inside the 32x16 field.
  assign in_reg = video_on && (x >= X0) && (x < X0 + 10'd32) &&
                  (y >= Y0) && (y < Y0 + 10'd16);
  assign dx = x[4:0] - X0[4:0];
  assign dy = y[3:0] - Y0[3:0];

  assign zero_th = (disp_bcd[15:12] == 4'd0);
  assign zero_hu = zero_th && (disp_bcd[11:8] == 4'd0);
  assign zero_te = zero_hu && (disp_bcd[7:4] == 4'd0);

  always_comb begin
    digit = disp_bcd[3:0];
    blank = 1'b0;
    case (dx[4:3])
      2'd0: begin digit = disp_bcd[15:12]; blank = BLANK_LZ && zero_th; end
      2'd1: begin digit = disp_bcd[11:8];  blank = BLANK_LZ && zero_hu; end
      2'd2: begin digit = disp_bcd[7:4];   blank = BLANK_LZ && zero_te; end
      default: begin digit = disp_bcd[3:0]; blank = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= 8'h00;
      col_r    <= 3'd0;
      lit_r    <= 1'b0;
    end else begin
      rom_addr <= in_reg ? {digit, dy} : 8'h00;
      col_r    <= dx[2:0];
      lit_r    <= in_reg && !blank;
    end
  end

  // Glyph MSB is the leftmost pixel of the 8-pixel cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pixel_on <= 1'b0;
    else
      pixel_on <= lit_r && rom_data[3'd7 - col_r];
  end

endmodule
